// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: write pointer, memory strobe and address,
// read-pointer synchronizer, and registered full / almost_full / occupancy / overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = (1 << ADDR_SIZE) - 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst_n,
    input  logic                 wr_req,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_ptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   wr_count,
    output logic                 overflow
);

    localparam int A  = ADDR_SIZE;
    localparam int PW = ADDR_SIZE + 1;
    localparam logic [A:0] AFULL = PW'(AFULL_LEVEL);

    logic [SYNC_STAGES-1:0][A:0] sync;
    logic [A:0]                  rq;
    logic [A:0]                  rq_bin;
    logic [A:0]                  wbin;
    logic [A:0]                  wbin_next;
    logic [A:0]                  wgray_next;
    logic [A:0]                  count_next;
    logic                        full_next;

    // Plain flop chain; nothing combinational between stages.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            sync <= '0;
        end else begin
            sync[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync[i] <= sync[i-1];
        end
    end

    assign rq = sync[SYNC_STAGES-1];

    always_comb begin
        rq_bin = '0;
        for (int i = 0; i <= A; i++)
            rq_bin[i] = ^(rq >> i);
    end

    assign wr_en      = wr_req & ~full & wr_rst_n;
    assign wbin_next  = wbin + PW'(wr_en);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign count_next = wbin_next - rq_bin;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_next  = (wgray_next == {~rq[A:A-1], rq[A-2:0]});

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= wgray_next;
            full        <= full_next;
            almost_full <= (count_next >= AFULL);
            wr_count    <= count_next;
            overflow    <= wr_req & full;
        end
    end

    assign wr_addr = wbin[A-1:0];

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: occupancy-based reference model feeding a scoreboard queue,
// plus scenario tasks with targeted inline checks.
module tb_fifo_wr_ctrl;

    localparam int AW  = 4;
    localparam int AFL = 14;

    logic       wr_clk = 1'b0;
    logic       wr_rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [4:0] rd_ptr_gray = '0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_count;
    logic       overflow;

    fifo_wr_ctrl #(.ADDR_SIZE(AW), .SYNC_STAGES(2), .AFULL_LEVEL(AFL)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .wr_req(wr_req), .rd_ptr_gray(rd_ptr_gray),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray), .full(full),
        .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic [3:0] addr;
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic [4:0] cnt;
        logic       ovf;
    } obs_t;

    obs_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference state: writes accepted (mod 32), two-deep read-pointer delay, full flag
    logic [4:0] m_wbin = '0;
    logic [4:0] m_s0 = '0;
    logic [4:0] m_s1 = '0;
    logic       m_full = 1'b0;
    logic       last_en = 1'b0;

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // One cycle: drive, check the strobe, push the expected post-edge state, pop and compare.
    task automatic step(input logic req, input logic [4:0] rdg, input logic rst);
        logic       en;
        logic [4:0] wb;
        logic [4:0] cnt;
        obs_t       exp_o;
        obs_t       got;
        wr_req = req; rd_ptr_gray = rdg; wr_rst_n = rst;
        #1;
        en = req && !m_full && rst;
        total++;
        if (wr_en !== en) $display("FAIL wr_en t=%0t: got %b expected %b", $time, wr_en, en);
        else passed++;
        last_en = en;
        if (!rst) begin
            exp_o = '0;
            m_wbin = '0; m_full = 1'b0; m_s0 = '0; m_s1 = '0;
        end else begin
            wb  = m_wbin + 5'(en);
            cnt = wb - g2b(m_s1);
            exp_o.addr = wb[3:0];
            exp_o.gray = b2g(wb);
            exp_o.full = (cnt == 5'd16);
            exp_o.af   = (cnt >= 5'(AFL));
            exp_o.cnt  = cnt;
            exp_o.ovf  = req && m_full;
            m_wbin = wb; m_full = exp_o.full; m_s1 = m_s0; m_s0 = rdg;
        end
        sb_q.push_back(exp_o);
        @(posedge wr_clk);
        #1;
        got   = {wr_addr, wr_ptr_gray, full, almost_full, wr_count, overflow};
        exp_o = sb_q.pop_front();
        total++;
        if (got !== exp_o)
            $display("FAIL scoreboard t=%0t: got addr=%0d gray=%b full=%b af=%b cnt=%0d ovf=%b expected addr=%0d gray=%b full=%b af=%b cnt=%0d ovf=%b",
                     $time, got.addr, got.gray, got.full, got.af, got.cnt, got.ovf,
                     exp_o.addr, exp_o.gray, exp_o.full, exp_o.af, exp_o.cnt, exp_o.ovf);
        else passed++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd0, 1'b0);
            total++;
            if ({wr_en, wr_addr, wr_ptr_gray, full, almost_full, wr_count, overflow} !== 18'd0)
                $display("FAIL reset_outputs cyc=%0d: got en=%b addr=%0d gray=%b full=%b af=%b cnt=%0d ovf=%b expected all 0",
                         i, wr_en, wr_addr, wr_ptr_gray, full, almost_full, wr_count, overflow);
            else passed++;
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) begin
                total++;
                if (wr_addr !== 4'(k - 1)) $display("FAIL fill_addr k=%0d: got %0d expected %0d", k, wr_addr, k - 1);
                else passed++;
            end
            step(1'b1, 5'd0, 1'b1);
            if (k == 13 || k == 14) begin
                total++;
                if (almost_full !== (k == 14)) $display("FAIL fill_af k=%0d: got %b expected %b", k, almost_full, k == 14);
                else passed++;
            end
            if (k == 15 || k == 16) begin
                total++;
                if (full !== (k == 16)) $display("FAIL fill_full k=%0d: got %b expected %b", k, full, k == 16);
                else passed++;
            end
            if (k == 16) begin
                total++;
                if (wr_count !== 5'd16 || wr_ptr_gray !== 5'b11000)
                    $display("FAIL fill_at_full: got cnt=%0d gray=%b expected cnt=16 gray=11000", wr_count, wr_ptr_gray);
                else passed++;
            end
            if (k == 17) begin
                total++;
                if (overflow !== 1'b1 || wr_addr !== 4'd0 || last_en !== 1'b0)
                    $display("FAIL fill_overflow: got ovf=%b addr=%0d en=%b expected ovf=1 addr=0 en=0", overflow, wr_addr, last_en);
                else passed++;
            end
        end
        step(1'b0, 5'd0, 1'b1);
        total++;
        if (overflow !== 1'b0) $display("FAIL overflow_pulse: got %b expected 0", overflow);
        else passed++;
    endtask

    task automatic test_release();
        for (int e = 1; e <= 3; e++) begin
            step(1'b0, 5'b00001, 1'b1);
            total++;
            if (e < 3 && full !== 1'b1) $display("FAIL release_early e=%0d: got full=%b expected 1", e, full);
            else if (e == 3 && (full !== 1'b0 || wr_count !== 5'd15 || almost_full !== 1'b1))
                $display("FAIL release_edge3: got full=%b cnt=%0d af=%b expected full=0 cnt=15 af=1", full, wr_count, almost_full);
            else passed++;
        end
        step(1'b1, 5'b00001, 1'b1);
        total++;
        if (full !== 1'b1 || last_en !== 1'b1) $display("FAIL refill: got full=%b en=%b expected full=1 en=1", full, last_en);
        else passed++;
    endtask

    task automatic test_wrap();
        int         addr_wraps = 0;
        int         wbin_wraps = 0;
        int         w = 0;
        int         bad = 0;
        logic [4:0] pg;
        logic [3:0] pa;
        step(1'b0, 5'd0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            pg = wr_ptr_gray; pa = wr_addr;
            step(1'b1, b2g(5'((w >= 4) ? w - 4 : 0)), 1'b1);
            if (last_en) w++;
            if (full !== 1'b0 || !last_en || $countones(pg ^ wr_ptr_gray) != 1) bad++;
            if (pa == 4'd15 && wr_addr == 4'd0) addr_wraps++;
            if (pg == 5'b10000 && wr_ptr_gray == 5'b00000) wbin_wraps++;
        end
        total++;
        if (bad != 0 || addr_wraps != 2 || wbin_wraps != 1)
            $display("FAIL wrap: got bad=%0d addr_wraps=%0d wbin_wraps=%0d expected 0/2/1", bad, addr_wraps, wbin_wraps);
        else passed++;
    endtask

    task automatic test_mid_reset();
        step(1'b0, 5'd0, 1'b0);
        for (int n = 0; n < 10; n++) step(1'b1, 5'd0, 1'b1);
        total++;
        if (wr_addr !== 4'd10) $display("FAIL mid_pre: got addr=%0d expected 10", wr_addr);
        else passed++;
        step(1'b1, 5'd0, 1'b0);
        total++;
        if (wr_addr !== 4'd0 || wr_count !== 5'd0 || wr_ptr_gray !== 5'd0 || last_en !== 1'b0)
            $display("FAIL mid_reset: got addr=%0d cnt=%0d gray=%b en=%b expected all 0", wr_addr, wr_count, wr_ptr_gray, last_en);
        else passed++;
    endtask

    task automatic test_random();
        logic [4:0] rdb = '0;
        logic       req;
        step(1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            // First half leans toward filling, second half toward draining.
            req = (i < 500) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            if (rdb != m_wbin && ((i < 500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8)))
                rdb = rdb + 5'd1;
            step(req, b2g(rdb), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
